// File: rtl/conv_lbx_ctrl.sv
// conv_lbx_ctrl: line-buffer bank sequencer for the 5x5 convolution kernel.
// Handles frame priming, per-buffer push/pop strobes, column-valid timing, kernel credits and line-width checking.
module conv_lbx_ctrl #(
  parameter int RD_LAT      = 2,
  parameter int CRED_N      = 4,
  parameter int IMAGE_MAX_W = 64,
  parameter int COL_W       = $clog2(IMAGE_MAX_W)
) (
  input  logic       clk,
  input  logic       arst_n,
  input  logic       s_vld_i,
  input  logic       s_sof_i,
  input  logic       s_eol_i,
  output logic       s_rdy_o,
  output logic [4:1] lb_push_o,
  output logic [4:1] lb_pop_o,
  output logic       lb_sof_o,
  output logic       lb_eol_o,
  output logic       col_vld_o,
  output logic       col_sof_o,
  output logic       col_eol_o,
  input  logic       cred_ret_i,
  output logic [2:0] lines_o,
  output logic       err_o
);
  typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;
  state_t           state;
  logic             live, first, wset;
  logic [3:0]       cred;
  logic [COL_W-1:0] col, idx;
  logic [COL_W:0]   width, idx1;
  logic [2:0]       pipe [RD_LAT];
  logic             acc, take, produce, ret, wok, wrap, bad;
  logic [2:0]       lv, ln;
  // live holds ready low until the first clock after reset is released
  assign s_rdy_o   = live & ((state != RUN) | (cred != 4'd0));
  assign acc       = s_vld_i & s_rdy_o;
  assign take      = acc & ((state != IDLE) | s_sof_i);
  assign produce   = acc & (state == RUN) & ~s_sof_i;
  assign ret       = cred_ret_i & (cred != 4'(CRED_N));
  assign lv        = s_sof_i ? 3'd0 : lines_o;
  assign ln        = lv + {2'b0, s_eol_i & (lv != 3'd4)};
  assign idx       = s_sof_i ? '0 : col;
  assign idx1      = {1'b0, idx} + (COL_W+1)'(1);
  assign wok       = wset & ~s_sof_i;
  assign wrap      = ~s_eol_i & (idx == COL_W'(IMAGE_MAX_W-1));
  assign bad       = (s_sof_i & (state != IDLE) & (col != '0)) | (s_eol_i & wok & (idx1 != width)) | wrap;
  assign lb_sof_o  = take & s_sof_i;
  assign lb_eol_o  = take & s_eol_i;
  assign lb_push_o = {take & (lv >= 3'd3), take & (lv >= 3'd2), take & (lv >= 3'd1), take};
  assign lb_pop_o  = {take & (lv == 3'd4), take & (lv >= 3'd3), take & (lv >= 3'd2), take & (lv >= 3'd1)};
  assign {col_vld_o, col_sof_o, col_eol_o} = pipe[RD_LAT-1];
  always_ff @(posedge clk or negedge arst_n)
    if (!arst_n) begin
      state   <= IDLE;
      live    <= 1'b0;
      first   <= 1'b0;
      wset    <= 1'b0;
      cred    <= 4'(CRED_N);
      col     <= '0;
      width   <= '0;
      lines_o <= '0;
      err_o   <= 1'b0;
      for (int i = 0; i < RD_LAT; i++) pipe[i] <= '0;
    end else begin
      live <= 1'b1;
      if (take) begin
        lines_o <= ln;
        state   <= (ln == 3'd4) ? RUN : FILL;
        col     <= (s_eol_i | wrap) ? '0 : idx + COL_W'(1);
        first   <= s_sof_i | (first & ~produce);
        if (s_sof_i & ~s_eol_i) wset <= 1'b0;
        if (s_eol_i & ~wok) begin
          width <= idx1;
          wset  <= 1'b1;
        end
        if (bad) err_o <= 1'b1;
      end
      if (produce & ~cred_ret_i) cred <= cred - 4'd1;
      else if (ret & ~produce) cred <= cred + 4'd1;
      pipe[0] <= {produce, produce & first, produce & s_eol_i};
      for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    end
endmodule
